// File: rtl/mac_cluster_sequencer.sv
// Sequencer for a 4-lane MAC cluster: serially loads the config chain,
// runs operand jobs through the cluster, and holds the result for the consumer.
module mac_cluster_sequencer #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int CNT_WIDTH      = 8,
  parameter int DRAIN_CYCLES   = 2,
  parameter int CHAIN_LEN      = 4 * MAC_CONF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CHAIN_LEN-1:0]       cfg_data,
  input  logic                       job_start,
  input  logic [CNT_WIDTH-1:0]       job_len,
  output logic                       job_busy,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0] op_a,
  input  logic [4*MAC_MIN_WIDTH-1:0] op_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [4*MAC_ACC_WIDTH-1:0] res_data,
  output logic                       mac_rst,
  output logic                       mac_en,
  output logic                       mac_cen,
  output logic                       mac_cset,
  output logic                       mac_shift,
  output logic [4*MAC_MIN_WIDTH-1:0] mac_a,
  output logic [4*MAC_MIN_WIDTH-1:0] mac_b,
  input  logic [4*MAC_ACC_WIDTH-1:0] mac_out
);

  localparam int BIT_W   = $clog2(CHAIN_LEN + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);

  typedef enum logic [2:0] {
    IDLE, SHIFT, SET, CLEAR, RUN, DRAIN, RESULT
  } state_t;

  state_t               state, state_next;
  logic [CHAIN_LEN-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 mac_en_q;

  // Config takes priority over a job request arriving in the same idle cycle.
  logic job_go;
  assign job_go = job_start && (job_len != '0);

  // All strobes decode from the state register alone, so an async reset to
  // IDLE silences them the instant rst falls.
  assign cfg_ready = (state == IDLE);
  assign job_busy  = (state != IDLE);
  assign mac_cen   = (state == SHIFT);
  assign mac_shift = (state == SHIFT) && shift_reg[CHAIN_LEN-1];
  assign mac_cset  = (state == SET);
  assign mac_rst   = (state == CLEAR);
  assign op_ready  = (state == RUN);
  assign res_valid = (state == RESULT);
  assign mac_en    = mac_en_q;

  always_comb begin
    // NOTE: default assigned first so every path drives state_next; no latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cfg_valid)   state_next = SHIFT;
        else if (job_go) state_next = CLEAR;
      end
      SHIFT:  if (bit_cnt == BIT_W'(1)) state_next = SET;
      SET:    state_next = IDLE;
      CLEAR:  state_next = RUN;
      RUN:    if (op_valid && beat_cnt == CNT_WIDTH'(1)) state_next = DRAIN;
      DRAIN:  if (drain_cnt == '0) state_next = RESULT;
      RESULT: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      mac_en_q  <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_data  <= '0;
    end else begin
      state    <= state_next;
      mac_en_q <= op_valid && op_ready;
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            shift_reg <= cfg_data;
            bit_cnt   <= BIT_W'(CHAIN_LEN);
          end else if (job_go) begin
            beat_cnt <= job_len;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[CHAIN_LEN-2:0], 1'b0};
          bit_cnt   <= bit_cnt - BIT_W'(1);
        end
        RUN: begin
          if (op_valid) begin
            mac_a    <= op_a;
            mac_b    <= op_b;
            beat_cnt <= beat_cnt - CNT_WIDTH'(1);
            // Drain spans DRAIN_CYCLES+1 cycles so the trailing mac_en lands.
            if (beat_cnt == CNT_WIDTH'(1)) drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) res_data  <= mac_out;
          else                 drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_cluster_sequencer.sv
// Directed bench for mac_cluster_sequencer with a behavioural 4-lane MAC
// cluster attached to the mac_* side.
module tb_mac_cluster_sequencer;

  logic         clk;
  logic         rst;
  logic         cfg_valid, cfg_ready;
  logic [15:0]  cfg_data;
  logic         job_start;
  logic [7:0]   job_len;
  logic         job_busy;
  logic         op_valid, op_ready;
  logic [31:0]  op_a, op_b;
  logic         res_valid, res_ready;
  logic [127:0] res_data;
  logic         mac_rst, mac_en, mac_cen, mac_cset, mac_shift;
  logic [31:0]  mac_a, mac_b;
  logic [127:0] mac_out;

  int checks = 0;
  int errors = 0;

  mac_cluster_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .job_start(job_start), .job_len(job_len), .job_busy(job_busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_cen(mac_cen), .mac_cset(mac_cset),
    .mac_shift(mac_shift), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cluster model: per-lane accumulate of 8x8 products, cleared by mac_rst.
  logic [31:0] acc [4];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (mac_rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (mac_en) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= acc[i] + 32'(mac_a[i*8 +: 8]) * 32'(mac_b[i*8 +: 8]);
    end
  end
  assign mac_out = {acc[3], acc[2], acc[1], acc[0]};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps negedges from the current one until res_valid, counting mac_en.
  task automatic run_job(input int max_cyc, output int en_cnt, output int en_first,
                         output int en_last, output int res_idx);
    en_cnt = 0; en_first = -1; en_last = -1; res_idx = -1;
    for (int idx = 0; idx < max_cyc; idx++) begin
      if (res_valid) begin
        res_idx = idx;
        break;
      end
      if (mac_en) begin
        en_cnt++;
        if (en_first < 0) en_first = idx;
        en_last = idx;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int en_cnt, en_first, en_last, res_idx, gap, strobes;
    logic [15:0] bits;
    logic [127:0] exp_stall;

    rst = 1'b0; cfg_valid = 0; cfg_data = '0; job_start = 0; job_len = '0;
    op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;

    // Reset state
    #12;
    check("rst_strobes", {mac_rst, mac_en, mac_cen, mac_cset, mac_shift, op_ready, res_valid, job_busy}, '0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_mac_ab", {mac_a, mac_b}, '0);
    check("rst_res_data", res_data, '0);
    @(negedge clk); rst = 1'b1;

    // Config load 16'hA5C3
    @(negedge clk); cfg_valid = 1; cfg_data = 16'hA5C3;
    @(negedge clk); cfg_valid = 0;
    bits = '0; en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bits = {bits[14:0], mac_shift};
      en_cnt += int'(mac_cen);
      if (mac_cset) en_cnt += 100;
      @(negedge clk);
    end
    check("cfg_shift_seq", bits, 16'hA5C3);
    check("cfg_cen_cycles", en_cnt, 16);
    check("cfg_set_pulse", {mac_cset, mac_cen, mac_shift}, 3'b100);
    @(negedge clk);
    check("cfg_back_idle", {cfg_ready, mac_cset, job_busy}, 3'b100);

    // Job run: 3 beats of 0x01 x 0x01 per lane
    job_start = 1; job_len = 8'd3; op_valid = 1; op_a = 32'h01010101; op_b = 32'h01010101;
    @(negedge clk); job_start = 0;
    check("job_clear", {mac_rst, op_ready, job_busy, mac_en}, 4'b1010);
    @(negedge clk);
    check("job_run_entry", {op_ready, mac_rst}, 2'b10);
    run_job(20, en_cnt, en_first, en_last, res_idx);
    check("job_en_count", en_cnt, 3);
    check("job_en_span", {en_first, en_last}, {32'd1, 32'd3});
    check("job_res_idx", res_idx, 6);
    check("job_res_data", res_data, {4{32'd3}});
    check("job_mac_a", mac_a, 32'h01010101);
    op_valid = 0; res_ready = 1;
    @(negedge clk); res_ready = 0;
    check("job_consumed", {res_valid, job_busy, cfg_ready}, 3'b001);
    check("job_res_held", res_data, {4{32'd3}});

    // Stall and backpressure
    job_start = 1; job_len = 8'd2;
    @(negedge clk); job_start = 0;
    op_valid = 1; op_a = 32'h04030201; op_b = 32'h05060708;
    @(negedge clk);
    check("stall_run0", {op_ready, mac_en}, 2'b10);
    @(negedge clk);
    check("stall_beat1_en", mac_en, 1'b1);
    check("stall_beat1_a", mac_a, 32'h04030201);
    op_valid = 0; op_a = 32'hDEADBEEF; op_b = 32'hDEADBEEF;
    gap = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gap += int'(mac_en);
      gap += op_ready ? 0 : 100;
    end
    check("stall_gap_no_en", gap, 0);
    check("stall_a_held", mac_a, 32'h04030201);
    op_valid = 1; op_a = 32'h01010101; op_b = 32'h02020202;
    @(negedge clk); op_valid = 0;
    check("stall_beat2_en", {mac_en, op_ready, job_busy}, 3'b101);
    run_job(10, en_cnt, en_first, en_last, res_idx);
    check("stall_drain_en", en_cnt, 1);
    check("stall_res_idx", res_idx, 3);
    exp_stall = {32'd22, 32'd20, 32'd16, 32'd10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid_held", res_valid, 1'b1);
      check("bp_data_held", res_data, exp_stall);
    end
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    check("bp_consumed", {res_valid, job_busy}, 2'b00);

    // Collision: config wins, job dropped
    cfg_valid = 1; cfg_data = 16'h0001; job_start = 1; job_len = 8'd5;
    @(negedge clk); cfg_valid = 0; job_start = 0;
    check("coll_shift", {mac_cen, mac_rst, op_ready}, 3'b100);
    strobes = 0;
    for (int i = 0; i < 17; i++) begin
      strobes += int'(mac_rst) + int'(op_ready);
      @(negedge clk);
    end
    check("coll_no_job", strobes, 0);
    check("coll_idle", {cfg_ready, job_busy}, 2'b10);

    // job_start with job_len == 0 is ignored
    job_start = 1; job_len = 8'd0;
    @(negedge clk); job_start = 0;
    check("len0_ignored", {job_busy, mac_rst, cfg_ready}, 3'b001);

    // Reset mid-SHIFT after 7 bits
    cfg_valid = 1; cfg_data = 16'hA5C3;
    @(negedge clk); cfg_valid = 0;
    repeat (7) @(negedge clk);
    check("rstsh_in_shift", mac_cen, 1'b1);
    rst = 1'b0;
    #1;
    check("rstsh_strobes", {mac_rst, mac_en, mac_cen, mac_cset, mac_shift, op_ready, res_valid, job_busy}, '0);
    check("rstsh_cfg_ready", cfg_ready, 1'b1);
    check("rstsh_regs", {mac_a, mac_b, res_data}, '0);
    strobes = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      strobes += int'(mac_cset) + int'(mac_cen);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      strobes += int'(mac_cset) + int'(mac_cen) + int'(job_busy);
    end
    check("rstsh_no_cset", strobes, 0);
    check("rstsh_idle", cfg_ready, 1'b1);

    // Max length job
    job_start = 1; job_len = 8'd255; op_valid = 1; op_a = 32'h01010101; op_b = 32'h01010101;
    @(negedge clk); job_start = 0;
    check("max_clear", mac_rst, 1'b1);
    @(negedge clk);
    run_job(400, en_cnt, en_first, en_last, res_idx);
    op_valid = 0;
    check("max_en_count", en_cnt, 255);
    check("max_res_idx", res_idx, 258);
    check("max_res_data", res_data, {4{32'd255}});
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    check("max_consumed", {res_valid, job_busy}, 2'b00);
    @(negedge clk);
    check("max_single_result", res_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
